// File: rtl/bram_arb_pkg.sv
// Shared parameters and read-owner tag types for the two-port BRAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bram_arb_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 64;
  localparam int RD_LAT_DEF = 3;

  // Requester identity carried alongside each outstanding read
  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

  typedef struct packed {
    logic   vld;
    owner_e id;
  } rd_tag_t;

  // Round-robin: after serving one requester the other gets priority
  function automatic owner_e other_owner(input owner_e o);
    return (o == OWN_M0) ? OWN_M1 : OWN_M0;
  endfunction

endpackage

// File: rtl/bram_rd_tag_pipe.sv
// Tracks the owner of every issued read so the fixed-latency return can be steered.
// Latency: a tag pushed with bram_start appears at head_o exactly RD_LAT cycles later.
// Backpressure: none; one push per cycle, returns are never stalled.
module bram_rd_tag_pipe
  import bram_arb_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push_i,
  input  owner_e  push_id_i,
  output rd_tag_t head_o,
  output logic    mask_o
);

  localparam int                CNT_W    = $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(RD_LAT);

  rd_tag_t          tag_q [RD_LAT];
  logic [CNT_W-1:0] mask_cnt_q;

  // Shift one stage per cycle; reset drops every in-flight read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= '{vld: push_i, id: push_id_i};
      for (int i = 1; i < RD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Count down RD_LAT cycles after reset so stale driver returns are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_cnt_q <= CNT_INIT;
    end else if (mask_cnt_q != '0) begin
      mask_cnt_q <= mask_cnt_q - 1'b1;
    end
  end

  assign head_o = tag_q[RD_LAT-1];
  assign mask_o = (mask_cnt_q != '0);

endmodule

// File: rtl/bram_arbiter.sv
// Two-requester round-robin arbiter in front of a single fixed-latency BRAM port.
// Latency: grant is combinational; command issued 1 cycle later; read data RD_LAT after issue.
// Backpressure: requesters hold req until gnt; at most one grant per cycle, returns never stall.
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  output logic              bram_wr,
  output logic              bram_start,
  input  logic [DATA_W-1:0] bram_rdata,
  input  logic              bram_valid,
  output logic              err
);

  owner_e            prio_q, prio_d;
  logic              gnt0, gnt1;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              start_q, start_d;
  owner_e            owner_q, owner_d;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              err_q, err_d;
  rd_tag_t           head;
  logic              mask;
  logic              ret_ok;

  // Round-robin grant; nothing is granted while reset is held
  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    prio_d = prio_q;
    if (!rst) begin
      if (m0_req && (!m1_req || prio_q == OWN_M0)) begin
        gnt0 = 1'b1;
      end else if (m1_req) begin
        gnt1 = 1'b1;
      end
    end
    if (gnt0 || gnt1) begin
      prio_d = other_owner(gnt0 ? OWN_M0 : OWN_M1);
    end
  end

  // Capture the granted command; strobes drop on idle, address and data hold
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = 1'b0;
    start_d = 1'b0;
    owner_d = owner_q;
    if (gnt0) begin
      addr_d  = m0_addr;
      wdata_d = m0_wdata;
      wr_d    = m0_wr;
      start_d = !m0_wr;
      owner_d = OWN_M0;
    end else if (gnt1) begin
      addr_d  = m1_addr;
      wdata_d = m1_wdata;
      wr_d    = m1_wr;
      start_d = !m1_wr;
      owner_d = OWN_M1;
    end
  end

  // Arbitration pointer and BRAM command registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q  <= OWN_M0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      start_q <= 1'b0;
      owner_q <= OWN_M0;
    end else begin
      prio_q  <= prio_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      start_q <= start_d;
      owner_q <= owner_d;
    end
  end

  bram_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .push_i    (start_q),
    .push_id_i (owner_q),
    .head_o    (head),
    .mask_o    (mask)
  );

  assign ret_ok    = bram_valid && !mask;
  assign m0_rvalid = ret_ok && head.vld && (head.id == OWN_M0);
  assign m1_rvalid = ret_ok && head.vld && (head.id == OWN_M1);

  // A return landing on an empty tag slot is a driver protocol error
  always_comb begin
    err_d = err_q | (ret_ok && !head.vld);
  end

  // Sticky error flag and last-returned read data per requester
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      err_q <= err_d;
      if (m0_rvalid) rdata0_q <= bram_rdata;
      if (m1_rvalid) rdata1_q <= bram_rdata;
    end
  end

  assign m0_gnt     = gnt0;
  assign m1_gnt     = gnt1;
  assign m0_rdata   = m0_rvalid ? bram_rdata : rdata0_q;
  assign m1_rdata   = m1_rvalid ? bram_rdata : rdata1_q;
  assign bram_addr  = addr_q;
  assign bram_wdata = wdata_q;
  assign bram_wr    = wr_q;
  assign bram_start = start_q;
  assign err        = err_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench: plays both requesters and a fixed-latency BRAM driver around bram_arbiter.
// Latency: checks every cycle against a transaction-level model of grants and returns.
// Backpressure: requests are held by the bench until the model expects a grant.
module tb_bram_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 64;
  localparam int RD_LAT = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              m0_req = 1'b0, m0_wr = 1'b0, m1_req = 1'b0, m1_wr = 1'b0;
  logic [ADDR_W-1:0] m0_addr = '0, m1_addr = '0;
  logic [DATA_W-1:0] m0_wdata = '0, m1_wdata = '0;
  logic              m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata;
  logic              bram_wr, bram_start, err;
  logic [DATA_W-1:0] bram_rdata = '0;
  logic              bram_valid = 1'b0;

  always #5 clk = ~clk;

  bram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_wr(bram_wr),
    .bram_start(bram_start), .bram_rdata(bram_rdata), .bram_valid(bram_valid),
    .err(err)
  );

  int errors = 0;
  int checks = 0;

  // Pending command per requester (held until granted)
  bit                p_req [2];
  bit                p_wr [2];
  logic [ADDR_W-1:0] p_addr [2];
  logic [DATA_W-1:0] p_wdata [2];

  // Reference model state
  logic [DATA_W-1:0] mem [1024];
  bit                sched_vld [8];
  logic [DATA_W-1:0] sched_dat [8];
  int                sched_own [8];
  bit                exp_vld = 0, exp_wr = 0, exp_err = 0;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [DATA_W-1:0] exp_wdata = '0;
  int                exp_own = 0;
  logic [DATA_W-1:0] exp_rdata [2];
  int                last_m = 1;
  int                since_rst = 0;
  int                cyc = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic set_req(input int m, input bit wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] wd);
    p_req[m] = 1; p_wr[m] = wr; p_addr[m] = a; p_wdata[m] = wd;
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    int r;
    r = $urandom_range(0, 8);
    return (r == 8) ? 10'h3FF : 10'(r);
  endfunction

  task automatic refill(input int pct, input bit rd_only);
    for (int m = 0; m < 2; m++) begin
      if (!p_req[m] && $urandom_range(0, 99) < pct) begin
        set_req(m, rd_only ? 1'b0 : 1'($urandom_range(0, 1)), rand_addr(), {$urandom, $urandom});
      end
    end
  endtask

  // One clock cycle: drive requester/driver inputs, compare all outputs, advance model
  task automatic step(input bit rst_now, input bit inj);
    int s, g, own, t;
    bit v, masked;
    logic [DATA_W-1:0] d;
    @(negedge clk);
    rst = rst_now;
    if (rst_now) begin
      for (int i = 0; i < 8; i++) sched_own[i] = -1;
      p_req[0] = 0; p_req[1] = 0;
      exp_vld = 0; exp_addr = '0; exp_wdata = '0; exp_err = 0;
      exp_rdata[0] = '0; exp_rdata[1] = '0; last_m = 1;
    end
    m0_req = p_req[0]; m0_wr = p_wr[0]; m0_addr = p_addr[0]; m0_wdata = p_wdata[0];
    m1_req = p_req[1]; m1_wr = p_wr[1]; m1_addr = p_addr[1]; m1_wdata = p_wdata[1];
    s   = cyc % 8;
    v   = sched_vld[s] || inj;
    own = sched_vld[s] ? sched_own[s] : -1;
    d   = sched_vld[s] ? sched_dat[s] : {$urandom, $urandom};
    sched_vld[s] = 0;
    bram_valid = v;
    bram_rdata = d;
    #1;
    masked = rst_now || (since_rst < RD_LAT);
    g = -1;
    if (!rst_now) begin
      if (p_req[0] && (!p_req[1] || last_m == 1)) g = 0;
      else if (p_req[1]) g = 1;
    end
    if (v && !masked && own >= 0) exp_rdata[own] = d;
    check("m0_gnt", m0_gnt, g == 0);
    check("m1_gnt", m1_gnt, g == 1);
    check("m0_rvalid", m0_rvalid, v && !masked && own == 0);
    check("m1_rvalid", m1_rvalid, v && !masked && own == 1);
    check("m0_rdata", m0_rdata, exp_rdata[0]);
    check("m1_rdata", m1_rdata, exp_rdata[1]);
    check("bram_wr", bram_wr, exp_vld && exp_wr);
    check("bram_start", bram_start, exp_vld && !exp_wr);
    check("bram_addr", bram_addr, exp_addr);
    check("bram_wdata", bram_wdata, exp_wdata);
    check("err", err, exp_err);
    // BRAM driver behaviour for the command issued this cycle
    if (exp_vld && exp_wr) mem[exp_addr] = exp_wdata;
    if (exp_vld && !exp_wr) begin
      t = (cyc + RD_LAT) % 8;
      sched_vld[t] = 1; sched_dat[t] = mem[exp_addr]; sched_own[t] = exp_own;
    end
    if (v && !masked && own < 0) exp_err = 1;
    exp_vld = (g >= 0);
    if (g >= 0) begin
      exp_wr = p_wr[g]; exp_addr = p_addr[g]; exp_wdata = p_wdata[g];
      exp_own = g; last_m = g; p_req[g] = 0;
    end
    since_rst = rst_now ? 0 : since_rst + 1;
    cyc++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 64'(i) * 64'h9E37_79B9_7F4A_7C15;
    mem[5] = 64'hA5;
    for (int i = 0; i < 8; i++) begin
      sched_vld[i] = 0; sched_dat[i] = '0; sched_own[i] = -1;
    end
    for (int m = 0; m < 2; m++) begin
      p_req[m] = 0; p_wr[m] = 0; p_addr[m] = '0; p_wdata[m] = '0; exp_rdata[m] = '0;
    end

    step(1, 0); step(1, 0);

    // Single read from m0 at 0x005
    set_req(0, 0, 10'h005, '0);
    repeat (6) step(0, 0);
    check("rd005_data", m0_rdata, 64'hA5);

    // Both requesting continuously from reset: alternating grants
    step(1, 0);
    for (int i = 0; i < 8; i++) begin refill(100, 0); step(0, 0); end
    repeat (5) step(0, 0);

    // m1 writes 0x3FF, then m0 reads it back
    set_req(1, 1, 10'h3FF, 64'h1234);
    step(0, 0);
    set_req(0, 0, 10'h3FF, '0);
    repeat (6) step(0, 0);
    check("rd3ff_data", m0_rdata, 64'h1234);

    // Four back-to-back reads with alternating owners
    for (int i = 0; i < 4; i++) begin
      if (i < 3) refill(100, 1);
      step(0, 0);
    end
    repeat (5) step(0, 0);

    // Random traffic
    repeat (400) begin refill(45, 0); step(0, 0); end
    repeat (6) step(0, 0);

    // Reset one cycle after two reads issue; stale returns must be masked
    set_req(0, 0, rand_addr(), '0);
    set_req(1, 0, rand_addr(), '0);
    step(0, 0); step(0, 0); step(0, 0);
    step(1, 0);
    repeat (6) step(0, 0);
    check("rst_mask_err", err, 0);

    // Spurious return with nothing outstanding sets sticky err
    step(0, 1);
    step(0, 0);
    check("spurious_err", err, 1);
    repeat (3) step(0, 0);
    step(1, 0);
    check("err_cleared", err, 0);
    step(0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 10, BRAM address width; DATA_W, default 64, BRAM data width; RD_LAT, default 3, cycles from bram_start to bram_valid.
REQ-002 clk  in  1  single clock, all state on posedge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 m0_req  in  1  requester 0 access request, held until granted.
REQ-005 m0_wr  in  1  requester 0 access type: 1 write, 0 read.
REQ-006 m0_addr  in  ADDR_W  requester 0 address.
REQ-007 m0_wdata  in  DATA_W  requester 0 write data.
REQ-008 m0_gnt  out  1  requester 0 access accepted this cycle (combinational).
REQ-009 m0_rvalid  out  1  requester 0 read data valid, one-cycle pulse.
REQ-010 m0_rdata  out  DATA_W  requester 0 read data.
REQ-011 m1_req, m1_wr, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata SHALL mirror REQ-004..010 for requester 1.
REQ-012 bram_addr  out  ADDR_W  registered address to BRAM driver.
REQ-013 bram_wdata  out  DATA_W  registered write data to BRAM driver.
REQ-014 bram_wr  out  1  registered write strobe.
REQ-015 bram_start  out  1  registered read-issue pulse.
REQ-016 bram_rdata  in  DATA_W  driver read data, valid with bram_valid.
REQ-017 bram_valid  in  1  driver read-return strobe.
REQ-018 err  out  1  sticky: bram_valid arrived with no read outstanding.

Function
REQ-019 Arbitration SHALL be two-way round-robin: single requester granted immediately; both requesting grants the one not granted last; at most one gnt per cycle.
REQ-020 Priority pointer SHALL update only on a grant; after reset, requester 0 has priority.
REQ-021 A grant in cycle t SHALL drive bram_addr/bram_wdata/bram_wr/bram_start with the granted command from posedge t+1 for exactly one cycle.
REQ-022 Granted write: bram_wr=1, bram_start=0; completes on issue, no response.
REQ-023 Granted read: bram_wr=0, bram_start=1; owner ID pushed into an RD_LAT-deep tag shift register.
REQ-024 Idle cycles SHALL drive bram_wr=0 and bram_start=0; bram_addr/bram_wdata hold last values.
REQ-025 On bram_valid with tag head valid: the owner's rvalid SHALL pulse the same cycle with rdata=bram_rdata; the other requester's rvalid SHALL stay 0.
REQ-026 Back-to-back reads (one per cycle) SHALL be sustained; returns SHALL be in issue order.
REQ-027 Reads and writes SHALL reach the BRAM in grant order; no address-hazard reordering.
REQ-028 bram_valid with tag head empty SHALL set err; err clears only on reset.
REQ-029 For RD_LAT cycles after reset deassertion, bram_valid SHALL be ignored (no rvalid, no err), masking driver returns issued before reset.
REQ-030 m*_rdata SHALL hold its value when rvalid=0.

Reset
REQ-031 While rst=1: m0_gnt=m1_gnt=0, m0/m1_rvalid=0, bram_wr=0, bram_start=0, bram_addr=0, bram_wdata=0, m0/m1_rdata=0, err=0, tag register empty, pointer at requester 0, post-reset mask counter loaded with RD_LAT.
REQ-032 Reset mid-operation SHALL discard all in-flight reads; no rvalid for them.

Structure
REQ-033 Package bram_arb_pkg SHALL hold ADDR_W, DATA_W, RD_LAT defaults and the owner-ID typedef (valid bit + 1-bit ID).
REQ-034 The tag shift register plus post-reset mask SHALL be sub-module bram_rd_tag_pipe; arbiter and command registers stay in bram_arbiter.

Verification
REQ-035 m0 read addr 0x005 alone, bram_valid 3 cycles after bram_start with data 0xA5 -> m0_rvalid pulses with rdata 0xA5, m1_rvalid stays 0.
REQ-036 m0 and m1 requesting continuously from reset -> grants alternate m0,m1,m0,m1; one bram command per cycle.
REQ-037 m1 write addr 0x3FF data 0x1234, then m0 read 0x3FF -> bram_wr then bram_start at 0x3FF in consecutive cycles; m0 receives 0x1234.
REQ-038 Four back-to-back reads alternating owners -> four rvalid pulses, in order, each to its issuer only.
REQ-039 Assert rst 1 cycle after two reads issued -> no rvalid, err=0 despite driver valids during mask window.
REQ-040 Inject bram_valid with no read outstanding -> err=1 next cycle, holds until rst.
